code_seq_gen: RTL

//   Stimulus-side partner of the 3-bit code relation detector. Emits a stream of W-bit code

---
 rtl/code_seq_pkg.sv | 19 +
 rtl/code_seq_gen_bin2gray.sv | 11 +
 rtl/code_seq_gen.sv | 134 +++++++++++++
 3 files changed

// File: rtl/code_seq_pkg.sv
// Shared types and constants for the code sequence generator.
package code_seq_pkg;

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_GRAY = 2'b10,
    MODE_EX3  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EMIT = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam int unsigned EX3_STEP = 3;

endpackage

// File: rtl/code_seq_gen_bin2gray.sv
// Combinational binary-to-gray converter, reusable by gray-domain blocks.
module bin2gray #(
  parameter int unsigned W = 3
) (
  input  logic [W-1:0] b,
  output logic [W-1:0] g
);

  assign g = b ^ (b >> 1);

endmodule

// File: rtl/code_seq_gen.sv
// Valid/ready generator of code-word sequences (UP, DOWN, GRAY, EX3).
// Optional CODE_SEQ_GEN_PAIR_OUT_EN adds out_prev/out_pair_valid for A/B pairing.
module code_seq_gen
  import code_seq_pkg::*;
#(
  parameter int unsigned W     = 3,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [1:0]       cfg_mode,
  input  logic [W-1:0]     cfg_seed,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_word,
  output logic             out_last,
  output logic             done,
  output logic             busy
`ifdef CODE_SEQ_GEN_PAIR_OUT_EN
  ,
  output logic [W-1:0]     out_prev,
  output logic             out_pair_valid
`endif
);

  state_e           state_q, state_d;
  mode_e            mode_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic [W-1:0]     bin_q;
  logic [W-1:0]     gray;
  logic [W-1:0]     code;
  logic             start_hs;
  logic             out_hs;
  logic             is_last;
  logic             load;
  logic             step;

  bin2gray #(.W(W)) u_bin2gray (
    .b (bin_q),
    .g (gray)
  );

  assign code     = (mode_q == MODE_GRAY) ? gray : bin_q;
  assign is_last  = (cnt_q == (len_q - LEN_W'(1)));
  assign start_hs = start_valid && start_ready;
  assign out_hs   = out_valid && out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath strobes; abort wins over the final handshake
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_hs) begin
          load    = 1'b1;
          state_d = (cfg_len == '0) ? ST_DONE : ST_EMIT;
        end
      end
      ST_EMIT: begin
        step = out_hs;
        if (abort) begin
          state_d = ST_IDLE;
        end else if (out_hs && is_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequence datapath: config latch, word counter and binary accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_UP;
      len_q  <= '0;
      cnt_q  <= '0;
      bin_q  <= '0;
    end else if (load) begin
      mode_q <= mode_e'(cfg_mode);
      len_q  <= cfg_len;
      cnt_q  <= '0;
      bin_q  <= cfg_seed;
    end else if (step) begin
      cnt_q <= cnt_q + LEN_W'(1);
      case (mode_q)
        MODE_DOWN: bin_q <= bin_q - W'(1);
        MODE_EX3:  bin_q <= bin_q + W'(EX3_STEP);
        default:   bin_q <= bin_q + W'(1);
      endcase
    end
  end

  assign start_ready = (state_q == ST_IDLE) && !rst;
  assign out_valid   = (state_q == ST_EMIT);
  assign out_word    = out_valid ? code : '0;
  assign out_last    = out_valid && is_last;
  assign done        = (state_q == ST_DONE);
  assign busy        = (state_q != ST_IDLE);

`ifdef CODE_SEQ_GEN_PAIR_OUT_EN
  logic [W-1:0] prev_q;

  // Last accepted word of the current sequence
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
    end else if (load) begin
      prev_q <= '0;
    end else if (step) begin
      prev_q <= code;
    end
  end

  assign out_prev       = prev_q;
  assign out_pair_valid = out_valid && (cnt_q != '0);
`endif

endmodule
